vdp_bus_ifce: RTL and testbench

- CPU-side front end for the VDP core: samples the asynchronous Z8S180 I/O strobes in the pixel-clock domain.
- Produces the one-cycle wr_tick/rd_tick, mode and din that the VDP consumes.
- Captures the VDP read data and holds it on the CPU data bus for the rest of the read cycle.
- Sits between the board-level I/O decode and the VDP core; all logic runs on the 25 MHz pixel clock.

---
 rtl/vdp_bus_pkg.sv | 17 +
 rtl/vdp_sync_bit.sv | 25 ++
 rtl/vdp_bus_ifce.sv | 125 ++++++++++++
 tb/tb_vdp_bus_ifce.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_bus_pkg.sv
// Shared constants for the VDP CPU bus front end: FSM encoding, default
// synchronizer depth and the register-select (mode) values.
package vdp_bus_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_TICK = 2'd1;
  localparam logic [1:0] WR_TICK = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam int SYNC_STAGES_DEF = 2;

  localparam logic MODE_VRAM = 1'b0;
  localparam logic MODE_CTRL = 1'b1;

endpackage

// File: rtl/vdp_sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low reset that
// presets every stage to RESET_VAL.
module vdp_sync_bit #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages_reg <= {N{RESET_VAL}};
    end else begin
      stages_reg <= {stages_reg[N-2:0], d};
    end
  end

  assign q = stages_reg[N-1];

endmodule

// File: rtl/vdp_bus_ifce.sv
// Z8S180 I/O strobe front end for the VDP: synchronizes the strobes, issues one
// rd_tick/wr_tick per access and holds read data. Optional macro VDP_BUS_WAIT_EN.
module vdp_bus_ifce
  import vdp_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  output logic       cpu_d_oe,
  output logic       cpu_wait_n,
  output logic       wr_tick,
  output logic       rd_tick,
  output logic       mode,
  output logic [7:0] din,
  input  logic [7:0] vdp_dout
);

  // Bit order: 0 = chip select, 1 = read strobe, 2 = write strobe (all active low).
  logic [2:0] pins_n;
  logic [2:0] sync_n;

  assign pins_n = {cpu_wr_n, cpu_rd_n, cpu_ce_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      vdp_sync_bit #(
        .N         (SYNC_STAGES),
        .RESET_VAL (1'b1)
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pins_n[gi]),
        .q     (sync_n[gi])
      );
    end
  endgenerate

  logic   rd_s_reg;
  logic   wr_s_reg;
  logic   origin_rd_reg;
  state_t state_reg;
  state_t state_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rd_s_reg && !wr_s_reg) begin
          state_next = RD_TICK;
        end else if (wr_s_reg && !rd_s_reg) begin
          state_next = WR_TICK;
        end
      end
      RD_TICK: state_next = HOLD;
      WR_TICK: state_next = HOLD;
      HOLD: begin
        // Leave only once the strobe that started this access has gone away.
        if (!(origin_rd_reg ? rd_s_reg : wr_s_reg)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_s_reg      <= 1'b0;
      wr_s_reg      <= 1'b0;
      state_reg     <= IDLE;
      origin_rd_reg <= 1'b0;
      mode          <= MODE_VRAM;
      din           <= 8'h00;
      cpu_d_out     <= 8'h00;
      cpu_d_oe      <= 1'b0;
    end else begin
      rd_s_reg  <= ~sync_n[0] & ~sync_n[1];
      wr_s_reg  <= ~sync_n[0] & ~sync_n[2];
      state_reg <= state_next;
      // Address and data pins have been stable for the whole synchronizer delay here.
      if (state_reg == IDLE && state_next != IDLE) begin
        mode          <= cpu_a0;
        din           <= cpu_d_in;
        origin_rd_reg <= (state_next == RD_TICK);
      end
      if (state_reg == RD_TICK) begin
        cpu_d_out <= vdp_dout;
      end
      cpu_d_oe <= (state_next == HOLD) & origin_rd_reg & rd_s_reg;
    end
  end

  assign rd_tick = (state_reg == RD_TICK);
  assign wr_tick = (state_reg == WR_TICK);

`ifdef VDP_BUS_WAIT_EN
  logic raw_access;
  logic done_reg;

  assign raw_access = ~cpu_ce_n & (~cpu_rd_n | ~cpu_wr_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      done_reg <= 1'b0;
    end else if (state_next == HOLD && state_reg != HOLD) begin
      done_reg <= 1'b1;
    end
  end

  // Wait is never requested while the interface is held in reset.
  assign cpu_wait_n = ~(raw_access & ~done_reg & reset);
`else
  assign cpu_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_bus_ifce.sv
// Self-checking bench for vdp_bus_ifce: directed scenarios plus randomized
// single accesses checked against latency/rule arithmetic.
module tb_vdp_bus_ifce;
  import vdp_bus_pkg::*;

  localparam int S = 2;
`ifdef VDP_BUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_ce_n = 1'b1;
  logic       cpu_rd_n = 1'b1;
  logic       cpu_wr_n = 1'b1;
  logic       cpu_a0 = 1'b0;
  logic [7:0] cpu_d_in = 8'h00;
  logic [7:0] cpu_d_out;
  logic       cpu_d_oe;
  logic       cpu_wait_n;
  logic       wr_tick;
  logic       rd_tick;
  logic       mode;
  logic [7:0] din;
  logic [7:0] vdp_dout;
  logic [7:0] rd_data = 8'h00;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         wr_cnt;
    int         rd_cnt;
    int         wr_at;
    int         rd_at;
    int         both;
    logic       mode_at;
    logic [7:0] din_at;
    int         oe_first;
    int         oe_last;
    int         oe_bad;
    logic [7:0] dout_end;
    logic       wait_start;
    int         wait_low;
    int         wait_last_low;
  } obs_t;

  // The VDP presents its read data only while rd_tick is high.
  assign vdp_dout = rd_tick ? rd_data : 8'hFF;

  always #20 clk = ~clk;

  vdp_bus_ifce #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_ce_n   (cpu_ce_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_a0     (cpu_a0),
    .cpu_d_in   (cpu_d_in),
    .cpu_d_out  (cpu_d_out),
    .cpu_d_oe   (cpu_d_oe),
    .cpu_wait_n (cpu_wait_n),
    .wr_tick    (wr_tick),
    .rd_tick    (rd_tick),
    .mode       (mode),
    .din        (din),
    .vdp_dout   (vdp_dout)
  );

  // Drives one CPU strobe for len clocks and records what happened on each
  // negedge sample; sample j follows clock edge j (edge 0 = first low sample).
  task automatic run_access(input logic rd, input logic wr, input logic a0,
                            input logic [7:0] d, input logic [7:0] rdat,
                            input int len, input int window, output obs_t o);
    o.wr_cnt = 0; o.rd_cnt = 0; o.wr_at = -1; o.rd_at = -1; o.both = 0;
    o.mode_at = 1'b0; o.din_at = 8'h00; o.oe_first = -1; o.oe_last = -1;
    o.oe_bad = 0; o.wait_low = 0; o.wait_last_low = -1;
    @(negedge clk);
    rd_data  = rdat;
    cpu_a0   = a0;
    cpu_d_in = d;
    cpu_ce_n = 1'b0;
    cpu_rd_n = !rd;
    cpu_wr_n = !wr;
    #1 o.wait_start = cpu_wait_n;
    for (int j = 0; j < window; j++) begin
      @(negedge clk);
      if (wr_tick) begin o.wr_cnt++; o.wr_at = j; o.mode_at = mode; o.din_at = din; end
      if (rd_tick) begin o.rd_cnt++; o.rd_at = j; o.mode_at = mode; end
      if (rd_tick && wr_tick) o.both++;
      if (cpu_d_oe) begin
        if (o.oe_first < 0) o.oe_first = j;
        o.oe_last = j;
        if (cpu_d_out !== rdat) o.oe_bad++;
      end
      if (!cpu_wait_n) begin o.wait_low++; o.wait_last_low = j; end
      if (j == len - 1) begin
        cpu_ce_n = 1'b1;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
      end
    end
    o.dout_end = cpu_d_out;
  endtask

  task automatic test_reset();
    #15;
    checks++; if (rd_tick !== 1'b0 || wr_tick !== 1'b0) begin errors++; $display("FAIL reset_ticks: got rd=%b wr=%b expected 0 0", rd_tick, wr_tick); end
    checks++; if (cpu_d_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", cpu_d_oe); end
    checks++; if (mode !== MODE_VRAM || din !== 8'h00) begin errors++; $display("FAIL reset_mode_din: got mode=%b din=%h expected 0 00", mode, din); end
    checks++; if (cpu_d_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", cpu_d_out); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b expected 1", cpu_wait_n); end
    @(negedge clk);
    reset = 1'b1;
    begin
      int ticks = 0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (rd_tick || wr_tick) ticks++;
      end
      checks++; if (ticks !== 0) begin errors++; $display("FAIL idle_no_tick: got %0d ticks expected 0", ticks); end
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    obs_t o;
    run_access(1'b0, 1'b1, 1'b1, 8'h81, 8'hFF, 10, 10 + S + 6, o);
    checks++; if (o.wr_cnt !== 1 || o.rd_cnt !== 0) begin errors++; $display("FAIL write_count: got wr=%0d rd=%0d expected 1 0", o.wr_cnt, o.rd_cnt); end
    checks++; if (o.wr_at !== S + 1) begin errors++; $display("FAIL write_latency: got %0d expected %0d", o.wr_at, S + 1); end
    checks++; if (o.mode_at !== MODE_CTRL || o.din_at !== 8'h81) begin errors++; $display("FAIL write_latch: got mode=%b din=%h expected 1 81", o.mode_at, o.din_at); end
    checks++; if (o.oe_first !== -1) begin errors++; $display("FAIL write_oe: got first oe at %0d expected none", o.oe_first); end
    $display("test_write: wr_tick at %0d mode=%b din=%h", o.wr_at, o.mode_at, o.din_at);
  endtask

  task automatic test_read();
    obs_t o;
    run_access(1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 10, 10 + S + 6, o);
    checks++; if (o.rd_cnt !== 1 || o.wr_cnt !== 0) begin errors++; $display("FAIL read_count: got rd=%0d wr=%0d expected 1 0", o.rd_cnt, o.wr_cnt); end
    checks++; if (o.rd_at !== S + 1 || o.mode_at !== MODE_VRAM) begin errors++; $display("FAIL read_tick: got at=%0d mode=%b expected %0d 0", o.rd_at, o.mode_at, S + 1); end
    checks++; if (o.oe_first !== S + 2 || o.oe_last !== 10 + S) begin errors++; $display("FAIL read_oe_window: got %0d..%0d expected %0d..%0d", o.oe_first, o.oe_last, S + 2, 10 + S); end
    checks++; if (o.oe_bad !== 0 || o.dout_end !== 8'h5A) begin errors++; $display("FAIL read_dout: got bad=%0d end=%h expected 0 5a", o.oe_bad, o.dout_end); end
    $display("test_read: rd_tick at %0d oe %0d..%0d dout=%h", o.rd_at, o.oe_first, o.oe_last, o.dout_end);
  endtask

  task automatic test_short();
    obs_t o;
    run_access(1'b0, 1'b1, 1'b0, 8'h3C, 8'hFF, 3, 3 + S + 8, o);
    checks++; if (o.wr_cnt !== 1 || o.wr_at !== S + 1) begin errors++; $display("FAIL short_write: got cnt=%0d at=%0d expected 1 %0d", o.wr_cnt, o.wr_at, S + 1); end
    checks++; if (o.din_at !== 8'h3C || o.mode_at !== MODE_VRAM) begin errors++; $display("FAIL short_latch: got din=%h mode=%b expected 3c 0", o.din_at, o.mode_at); end
    $display("test_short: wr_tick count %0d at %0d", o.wr_cnt, o.wr_at);
  endtask

  task automatic test_back_to_back();
    int wr_at = -1, rd_at = -1, wr_cnt = 0, rd_cnt = 0;
    logic [7:0] din_at = 8'h00;
    localparam int LW = 6, LR = 6;
    @(negedge clk);
    rd_data = 8'hC3; cpu_ce_n = 1'b0; cpu_a0 = 1'b1; cpu_d_in = 8'h12; cpu_wr_n = 1'b0;
    for (int j = 0; j < LW + 1 + LR + S + 6; j++) begin
      @(negedge clk);
      if (wr_tick) begin wr_cnt++; wr_at = j; din_at = din; end
      if (rd_tick) begin rd_cnt++; rd_at = j; end
      if (j == LW - 1) cpu_wr_n = 1'b1;
      if (j == LW) begin cpu_rd_n = 1'b0; cpu_a0 = 1'b0; end
      if (j == LW + LR) begin cpu_rd_n = 1'b1; cpu_ce_n = 1'b1; end
    end
    checks++; if (wr_cnt !== 1 || rd_cnt !== 1) begin errors++; $display("FAIL b2b_counts: got wr=%0d rd=%0d expected 1 1", wr_cnt, rd_cnt); end
    checks++; if (wr_at !== S + 1 || rd_at !== LW + 1 + S + 1) begin errors++; $display("FAIL b2b_order: got wr=%0d rd=%0d expected %0d %0d", wr_at, rd_at, S + 1, LW + S + 2); end
    checks++; if (din_at !== 8'h12 || cpu_d_out !== 8'hC3) begin errors++; $display("FAIL b2b_data: got din=%h dout=%h expected 12 c3", din_at, cpu_d_out); end
    $display("test_back_to_back: wr at %0d rd at %0d", wr_at, rd_at);
  endtask

  task automatic test_illegal();
    obs_t o;
    run_access(1'b1, 1'b1, 1'b1, 8'h77, 8'h99, 10, 10 + S + 6, o);
    checks++; if (o.wr_cnt !== 0 || o.rd_cnt !== 0 || o.oe_first !== -1) begin errors++; $display("FAIL illegal: got wr=%0d rd=%0d oe=%0d expected 0 0 -1", o.wr_cnt, o.rd_cnt, o.oe_first); end
    $display("test_illegal: wr=%0d rd=%0d", o.wr_cnt, o.rd_cnt);
  endtask

  task automatic test_reset_mid_read();
    int rd_cnt = 0, rd_at = -1;
    @(negedge clk);
    rd_data = 8'hA7; cpu_ce_n = 1'b0; cpu_a0 = 1'b1; cpu_rd_n = 1'b0;
    for (int j = 0; j <= S + 3; j++) @(negedge clk);
    checks++; if (cpu_d_oe !== 1'b1 || cpu_d_out !== 8'hA7) begin errors++; $display("FAIL mid_read_hold: got oe=%b dout=%h expected 1 a7", cpu_d_oe, cpu_d_out); end
    #5 reset = 1'b0;
    #1;
    checks++; if (cpu_d_oe !== 1'b0 || cpu_d_out !== 8'h00) begin errors++; $display("FAIL async_reset: got oe=%b dout=%h expected 0 00", cpu_d_oe, cpu_d_out); end
    checks++; if (mode !== 1'b0 || din !== 8'h00 || rd_tick !== 1'b0) begin errors++; $display("FAIL async_reset_regs: got mode=%b din=%h rd=%b expected 0 00 0", mode, din, rd_tick); end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 2 * S + 6; j++) begin
      @(negedge clk);
      if (rd_tick) begin rd_cnt++; rd_at = j; end
    end
    cpu_rd_n = 1'b1; cpu_ce_n = 1'b1;
    repeat (S + 6) @(negedge clk);
    checks++; if (rd_cnt !== 1 || rd_at !== S + 1) begin errors++; $display("FAIL post_reset_read: got cnt=%0d at=%0d expected 1 %0d", rd_cnt, rd_at, S + 1); end
    $display("test_reset_mid_read: new rd_tick count %0d at %0d", rd_cnt, rd_at);
  endtask

  task automatic test_wait();
    obs_t o;
    run_access(1'b1, 1'b0, 1'b0, 8'h00, 8'h3E, 10, 10 + S + 6, o);
    checks++; if (o.wait_start !== !WAIT_EN) begin errors++; $display("FAIL wait_start: got %b expected %b", o.wait_start, !WAIT_EN); end
    checks++; if (o.wait_low !== (WAIT_EN ? S + 2 : 0) || o.wait_last_low !== (WAIT_EN ? o.rd_at : -1)) begin
      errors++; $display("FAIL wait_release: got low=%0d last=%0d expected %0d %0d", o.wait_low, o.wait_last_low, WAIT_EN ? S + 2 : 0, WAIT_EN ? S + 1 : -1);
    end
    $display("test_wait: wait low for %0d samples, last at %0d", o.wait_low, o.wait_last_low);
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 16; n++) begin
      logic       is_rd = 1'($urandom_range(0, 1));
      logic       a0    = 1'($urandom_range(0, 1));
      logic [7:0] d     = 8'($urandom);
      logic [7:0] rdat  = 8'($urandom);
      int         len   = int'($urandom_range(1, 12));
      run_access(is_rd, !is_rd, a0, d, rdat, len, len + S + 6, o);
      checks++;
      if (o.both !== 0 || o.rd_cnt !== (is_rd ? 1 : 0) || o.wr_cnt !== (is_rd ? 0 : 1)
          || (is_rd ? o.rd_at : o.wr_at) !== S + 1 || o.mode_at !== a0 || (!is_rd && o.din_at !== d)) begin
        errors++;
        $display("FAIL rand_tick[%0d]: got rd=%0d@%0d wr=%0d@%0d mode=%b din=%h expected rd=%0d wr=%0d @%0d mode=%b din=%h",
                 n, o.rd_cnt, o.rd_at, o.wr_cnt, o.wr_at, o.mode_at, o.din_at, is_rd, !is_rd, S + 1, a0, d);
      end
      if (is_rd) begin
        checks++;
        if (o.oe_first !== (len >= 2 ? S + 2 : -1) || o.oe_last !== (len >= 2 ? len + S : -1)
            || o.oe_bad !== 0 || o.dout_end !== rdat) begin
          errors++;
          $display("FAIL rand_read[%0d]: got oe %0d..%0d bad=%0d dout=%h expected %0d..%0d dout=%h",
                   n, o.oe_first, o.oe_last, o.oe_bad, o.dout_end, len >= 2 ? S + 2 : -1, len >= 2 ? len + S : -1, rdat);
        end
      end
      $display("random %0d: %s len=%0d a0=%b d=%h rdat=%h tick at %0d", n, is_rd ? "read " : "write", len, a0, d, rdat,
               is_rd ? o.rd_at : o.wr_at);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_short();
    test_back_to_back();
    test_illegal();
    test_reset_mid_read();
    test_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
